// File: rtl/hazard_pkg.sv
// hazard_pkg: shared types and constants for the hazard unit (mul/div FSM states, register address width, zero register)
package hazard_pkg;
  typedef enum logic {IDLE = 1'b0, BUSY = 1'b1} muldiv_state_e;
  localparam int REG_ADDR_W = 5;
  localparam logic [REG_ADDR_W-1:0] REG_ZERO = 5'd0;
endpackage

// File: rtl/muldiv_tracker.sv
// muldiv_tracker: busy FSM for the multi-cycle mul/div unit
//   clk, reset          clock, asynchronous active-high reset
//   ex_muldiv_start     mul/div instruction in EX this cycle
//   muldiv_busy         FSM in BUSY
//   muldiv_done         pulse in the last BUSY cycle
module muldiv_tracker
  import hazard_pkg::*;
#(
  parameter int MULDIV_LAT = 8
) (
  input  logic clk,
  input  logic reset,
  input  logic ex_muldiv_start,
  output logic muldiv_busy,
  output logic muldiv_done
);
  localparam int CW = $clog2(MULDIV_LAT);
  localparam logic [CW-1:0] LOAD = CW'(MULDIV_LAT - 2);
  muldiv_state_e r_state, w_state_nxt;
  logic [CW-1:0] r_cnt, w_cnt_nxt;
  // a start always (re)loads, even if one arrives illegally while BUSY
  always_comb begin
    w_state_nxt = ex_muldiv_start ? BUSY : (r_state == BUSY && r_cnt == '0) ? IDLE : r_state;
    w_cnt_nxt = ex_muldiv_start ? LOAD : (r_state == BUSY && r_cnt != '0) ? r_cnt - 1'b1 : r_cnt;
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= IDLE;
      r_cnt <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt <= w_cnt_nxt;
    end
  end
  assign muldiv_busy = r_state == BUSY;
  assign muldiv_done = r_state == BUSY && r_cnt == '0;
endmodule

// File: rtl/hazard_unit.sv
// hazard_unit: load-use / HI-LO stall and EX-redirect flush control with stall/flush performance counters
//   clk, reset                      clock, asynchronous active-high reset
//   id_rs, id_rt, id_uses_rs/rt     ID source registers and their use flags
//   id_hilo_use                     ID instruction reads HI/LO or is a mul/div
//   ex_mem_read, ex_rt              EX load and its destination
//   ex_redirect                     taken branch / jump resolves in EX
//   ex_muldiv_start                 mul/div in EX
//   pc_stall, if_id_stall, id_ex_bubble, if_id_flush, id_ex_flush   pipeline controls
//   muldiv_busy, muldiv_done        mul/div tracker status
//   stall_cnt, flush_cnt            wrapping stall/flush cycle counters
module hazard_unit
  import hazard_pkg::*;
#(
  parameter int MULDIV_LAT = 8,
  parameter int CNT_W = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [REG_ADDR_W-1:0] id_rs,
  input  logic [REG_ADDR_W-1:0] id_rt,
  input  logic                  id_uses_rs,
  input  logic                  id_uses_rt,
  input  logic                  id_hilo_use,
  input  logic                  ex_mem_read,
  input  logic [REG_ADDR_W-1:0] ex_rt,
  input  logic                  ex_redirect,
  input  logic                  ex_muldiv_start,
  output logic                  pc_stall,
  output logic                  if_id_stall,
  output logic                  if_id_flush,
  output logic                  id_ex_bubble,
  output logic                  id_ex_flush,
  output logic                  muldiv_busy,
  output logic                  muldiv_done,
  output logic [CNT_W-1:0]      stall_cnt,
  output logic [CNT_W-1:0]      flush_cnt
);
  logic w_lu, w_hl, w_stall, w_flush;
  logic [CNT_W-1:0] r_stall_cnt, r_flush_cnt;
  muldiv_tracker #(.MULDIV_LAT(MULDIV_LAT)) u_tracker (
    .clk(clk),
    .reset(reset),
    .ex_muldiv_start(ex_muldiv_start),
    .muldiv_busy(muldiv_busy),
    .muldiv_done(muldiv_done)
  );
  assign w_lu = ex_mem_read & (ex_rt != REG_ZERO)
              & ((id_uses_rs & (id_rs == ex_rt)) | (id_uses_rt & (id_rt == ex_rt)));
  assign w_hl = id_hilo_use & (ex_muldiv_start | muldiv_busy);
  // redirect squashes the stalled instruction anyway, so it wins over any hazard
  assign w_stall = ~reset & ~ex_redirect & (w_lu | w_hl);
  assign w_flush = ~reset & ex_redirect;
  assign pc_stall = w_stall;
  assign if_id_stall = w_stall;
  assign id_ex_bubble = w_stall;
  assign if_id_flush = w_flush;
  assign id_ex_flush = w_flush;
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_stall_cnt <= '0;
      r_flush_cnt <= '0;
    end else begin
      r_stall_cnt <= r_stall_cnt + CNT_W'(w_stall);
      r_flush_cnt <= r_flush_cnt + CNT_W'(ex_redirect);
    end
  end
  assign stall_cnt = r_stall_cnt;
  assign flush_cnt = r_flush_cnt;
endmodule

// File: tb/tb_hazard_unit.sv
// tb_hazard_unit: directed self-checking bench for hazard_unit (MULDIV_LAT=8, CNT_W=4)
module tb_hazard_unit;
  logic clk = 1'b0;
  logic reset;
  logic [4:0] id_rs, id_rt, ex_rt;
  logic id_uses_rs, id_uses_rt, id_hilo_use, ex_mem_read, ex_redirect, ex_muldiv_start;
  logic pc_stall, if_id_stall, if_id_flush, id_ex_bubble, id_ex_flush, muldiv_busy, muldiv_done;
  logic [3:0] stall_cnt, flush_cnt;
  int total = 0;
  int bad = 0;

  hazard_unit #(.MULDIV_LAT(8), .CNT_W(4)) dut (
    .clk(clk), .reset(reset),
    .id_rs(id_rs), .id_rt(id_rt), .id_uses_rs(id_uses_rs), .id_uses_rt(id_uses_rt),
    .id_hilo_use(id_hilo_use), .ex_mem_read(ex_mem_read), .ex_rt(ex_rt),
    .ex_redirect(ex_redirect), .ex_muldiv_start(ex_muldiv_start),
    .pc_stall(pc_stall), .if_id_stall(if_id_stall), .if_id_flush(if_id_flush),
    .id_ex_bubble(id_ex_bubble), .id_ex_flush(id_ex_flush),
    .muldiv_busy(muldiv_busy), .muldiv_done(muldiv_done),
    .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] want);
    total++;
    assert (obs === want) else begin
      bad++;
      $error("FAIL %s got=%0h want=%0h", tag, obs, want);
    end
  endtask

  task automatic ctl(input string tag, input logic stall, input logic flush);
    check({tag, ".pc_stall"}, 32'(pc_stall), 32'(stall));
    check({tag, ".if_id_stall"}, 32'(if_id_stall), 32'(stall));
    check({tag, ".id_ex_bubble"}, 32'(id_ex_bubble), 32'(stall));
    check({tag, ".if_id_flush"}, 32'(if_id_flush), 32'(flush));
    check({tag, ".id_ex_flush"}, 32'(id_ex_flush), 32'(flush));
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic clear;
    id_rs = 0; id_rt = 0; ex_rt = 0;
    id_uses_rs = 0; id_uses_rt = 0; id_hilo_use = 0;
    ex_mem_read = 0; ex_redirect = 0; ex_muldiv_start = 0;
  endtask

  initial begin
    clear();
    reset = 1'b1;
    ex_mem_read = 1; ex_rt = 8; id_uses_rs = 1; id_rs = 8; ex_redirect = 1; id_hilo_use = 1;
    #3;
    ctl("reset_forced", 1'b0, 1'b0);
    tick();
    tick();
    check("reset_stall_cnt", 32'(stall_cnt), 0);
    check("reset_flush_cnt", 32'(flush_cnt), 0);
    check("reset_busy", 32'(muldiv_busy), 0);
    check("reset_done", 32'(muldiv_done), 0);
    clear();
    reset = 1'b0;
    #1;
    ctl("idle", 1'b0, 1'b0);

    ex_mem_read = 1; ex_rt = 8; id_uses_rs = 1; id_rs = 8;
    #1;
    ctl("lu_rs", 1'b1, 1'b0);
    tick();
    check("lu_rs_cnt", 32'(stall_cnt), 1);
    clear();
    #1;
    ctl("lu_gone", 1'b0, 1'b0);

    ex_mem_read = 1; ex_rt = 0; id_uses_rs = 1; id_rs = 0;
    #1;
    ctl("lu_zero", 1'b0, 1'b0);
    tick();
    check("lu_zero_cnt", 32'(stall_cnt), 1);
    clear();

    ex_mem_read = 1; ex_rt = 8; id_uses_rs = 1; id_rs = 9;
    #1;
    ctl("lu_nomatch", 1'b0, 1'b0);
    id_uses_rs = 0; id_uses_rt = 1; id_rt = 8;
    #1;
    ctl("lu_rt", 1'b1, 1'b0);
    tick();
    check("lu_rt_cnt", 32'(stall_cnt), 2);
    clear();

    ex_mem_read = 1; ex_rt = 8; id_uses_rs = 1; id_rs = 8; ex_redirect = 1;
    #1;
    ctl("prio", 1'b0, 1'b1);
    tick();
    check("prio_flush_cnt", 32'(flush_cnt), 1);
    check("prio_stall_cnt", 32'(stall_cnt), 2);
    clear();

    ex_muldiv_start = 1; id_hilo_use = 1;
    #1;
    ctl("md_start", 1'b1, 1'b0);
    check("md_start_busy", 32'(muldiv_busy), 0);
    tick();
    ex_muldiv_start = 0;
    for (int i = 0; i < 7; i++) begin
      #1;
      check($sformatf("md_busy%0d", i), 32'(muldiv_busy), 1);
      check($sformatf("md_done%0d", i), 32'(muldiv_done), 32'(i == 6));
      check($sformatf("md_stall%0d", i), 32'(pc_stall), 1);
      tick();
    end
    check("md_end_busy", 32'(muldiv_busy), 0);
    check("md_end_done", 32'(muldiv_done), 0);
    ctl("md_release", 1'b0, 1'b0);
    check("md_stall_cnt", 32'(stall_cnt), 10);
    clear();

    ex_muldiv_start = 1;
    tick();
    ex_muldiv_start = 0;
    for (int i = 0; i < 7; i++) begin
      ex_redirect = (i == 2);
      #1;
      ctl($sformatf("rd%0d", i), 1'b0, i == 2);
      check($sformatf("rd_busy%0d", i), 32'(muldiv_busy), 1);
      check($sformatf("rd_done%0d", i), 32'(muldiv_done), 32'(i == 6));
      tick();
    end
    ex_redirect = 0;
    check("rd_end_busy", 32'(muldiv_busy), 0);
    check("rd_flush_cnt", 32'(flush_cnt), 2);
    check("rd_stall_cnt", 32'(stall_cnt), 10);

    ex_muldiv_start = 1;
    tick();
    ex_muldiv_start = 0;
    for (int i = 0; i < 3; i++) tick();
    id_hilo_use = 1;
    #1;
    check("ar_pre_stall", 32'(pc_stall), 1);
    check("ar_pre_busy", 32'(muldiv_busy), 1);
    #1;
    reset = 1'b1;
    #1;
    ctl("ar", 1'b0, 1'b0);
    check("ar_busy", 32'(muldiv_busy), 0);
    check("ar_done", 32'(muldiv_done), 0);
    check("ar_stall_cnt", 32'(stall_cnt), 0);
    check("ar_flush_cnt", 32'(flush_cnt), 0);
    tick();
    reset = 1'b0;
    #1;
    ctl("ar_release", 1'b0, 1'b0);
    check("ar_release_busy", 32'(muldiv_busy), 0);
    tick();
    check("ar_release_cnt", 32'(stall_cnt), 0);
    clear();

    ex_mem_read = 1; ex_rt = 3; id_uses_rt = 1; id_rt = 3;
    for (int i = 1; i <= 16; i++) begin
      tick();
      if (i == 15) check("wrap15", 32'(stall_cnt), 15);
    end
    check("wrap0", 32'(stall_cnt), 0);
    check("wrap_flush_cnt", 32'(flush_cnt), 0);
    clear();
    #1;
    ctl("final", 1'b0, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
